button_bounce_gen: RTL
======================

BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

Interface
REQ-001 SHALL have parameter BOUNCE_PAIRS, default 4: extra away-and-back toggle pairs after the first edge; 0 means a single clean edge.
REQ-002 SHALL have parameter GLITCH_MAX_CYCLES, default 16: power of two, >= 2; maximum hold time of one bounce level, in clk cycles.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 64, >= 1: stable cycles after the last edge before completion is reported.
REQ-004 SHALL have parameter SEED, default 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port press, input, 1 bit: clean requested button level.
REQ-008 SHALL have port button, output, 1 bit: emulated bouncing contact level.
REQ-009 SHALL have port busy, output, 1 bit: high in the BOUNCE and SETTLE states.
REQ-010 SHALL have port settled, output, 1 bit: one-cycle pulse when button has been stable at the target level for SETTLE_CYCLES cycles.

Function
REQ-011 SHALL implement states IDLE, BOUNCE and SETTLE, registered; all outputs registered.
REQ-012 In IDLE, SHALL sample press each cycle; if press != button, SHALL in the next cycle:
  - latch target = press;
  - toggle button (button now equals target);
  - load toggles_left = 2*BOUNCE_PAIRS;
  - load hold = 1 + (lfsr[log2(GLITCH_MAX_CYCLES)-1:0]);
  - enter BOUNCE, or enter SETTLE if toggles_left = 0.
REQ-013 In BOUNCE, SHALL decrement hold each cycle; when hold reaches 1, the next cycle SHALL toggle button, decrement toggles_left and reload hold from the current lfsr.
REQ-014 SHALL keep every bounce level for 1..GLITCH_MAX_CYCLES cycles inclusive.
REQ-015 After the final toggle (toggles_left = 0), button SHALL equal target, and the block SHALL enter SETTLE with settle counter = SETTLE_CYCLES.
REQ-016 Total edges per request SHALL be 1 + 2*BOUNCE_PAIRS (always odd).
REQ-017 In SETTLE, SHALL hold button constant and decrement the counter; at 0, SHALL pulse settled for exactly one cycle and return to IDLE in the same cycle.
REQ-018 SHALL ignore press changes during BOUNCE and SETTLE. If press differs from button on the first IDLE cycle, a new sequence SHALL start the following cycle, giving back-to-back requests one idle cycle.
REQ-019 The LFSR SHALL be a 16-bit Galois LFSR, taps 16'hB400, shifting right every cycle regardless of state; it SHALL never reach zero.
REQ-020 Counter widths SHALL be clog2-sized from the parameters; no counter SHALL wrap: hold >= 1 and settle >= 0 at all times.
REQ-021 busy SHALL be 0 in IDLE and 1 in BOUNCE and SETTLE; settled SHALL never be high while busy is 1 on the following cycle.

Reset
REQ-022 On reset = 1 at a clk edge, SHALL set:
  - state = IDLE;
  - button = 0, busy = 0, settled = 0;
  - counters = 0;
  - lfsr = SEED (or 1 if SEED = 0).
REQ-023 Reset during BOUNCE or SETTLE SHALL abort the sequence with no settled pulse; button SHALL be 0 on the next cycle.
REQ-024 Reset SHALL have priority over every other event in the same cycle.

Structure
REQ-025 Package button_bounce_pkg SHALL hold the state encoding (IDLE = 2'd0, BOUNCE = 2'd1, SETTLE = 2'd2), LFSR_TAPS = 16'hB400, and LFSR_WIDTH = 16.
REQ-026 The LFSR SHALL be a sub-module lfsr16 with ports clk, reset, seed and q; the FSM and counters stay in button_bounce_gen.

Verification
Bench parameters: BOUNCE_PAIRS = 3, GLITCH_MAX_CYCLES = 4, SETTLE_CYCLES = 10, SEED = 16'hACE1.
REQ-027 SHALL test reset: reset high for 3 cycles -> button = 0, busy = 0, settled = 0, and held while press = 0.
REQ-028 SHALL test a press: press 0->1 -> exactly 7 button edges, each level lasting 1..4 cycles, final button = 1, settled pulses once exactly 10 cycles after the last edge, then busy = 0.
REQ-029 SHALL test a press change mid-sequence: press 1->0 while busy -> no change to the edge count; the release sequence (7 edges, final 0) starts 2 cycles after settled.
REQ-030 SHALL test reset mid-bounce: reset asserted after the 3rd edge -> button = 0 next cycle, no settled pulse, IDLE.
REQ-031 SHALL test BOUNCE_PAIRS = 0: press 0->1 -> a single edge, settled pulse 10 cycles later.
REQ-032 SHALL test end to end: button feeds button_debounce (CLK_FREQUENCY = 10_000_000, DEBOUNCE_HZ = 2) -> exactly one debounce pulse per press.

Source files
------------

// File: rtl/button_bounce_pkg.sv
// Shared definitions for the button bounce generator.
// Contents: FSM state encoding, LFSR width/taps and the LFSR step function.
package button_bounce_pkg;

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // One right shift of a Galois LFSR; a nonzero value never maps to zero.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
        lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : LFSR_WIDTH'(0));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used as the bounce timing source.
// Ports: clk, reset (sync, active-high), seed (reset value, 0 maps to 1), q (state).
module lfsr16
    import button_bounce_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] q
);

    // An all-zero seed would lock the register, so substitute 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= (seed == LFSR_WIDTH'(0)) ? LFSR_WIDTH'(1) : seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/button_bounce_gen.sv
// Emulates a mechanical push-button: every change of the clean press level is
// turned into an odd number of button edges with random short levels, followed
// by a quiet settle period and a one-cycle settled pulse.
// Ports: clk, reset (sync, active-high), press (clean level in),
//        button (bouncing level out), busy (sequence running), settled (done pulse).
module button_bounce_gen
    import button_bounce_pkg::*;
#(
    parameter int unsigned BOUNCE_PAIRS      = 4,
    parameter int unsigned GLITCH_MAX_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES     = 64,
    parameter logic [15:0] SEED              = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic press,
    output logic button,
    output logic busy,
    output logic settled
);

    localparam int unsigned GLITCH_BITS = $clog2(GLITCH_MAX_CYCLES);
    localparam int unsigned HOLD_W      = $clog2(GLITCH_MAX_CYCLES + 1);
    localparam int unsigned TOGGLES     = 2 * BOUNCE_PAIRS;
    localparam int unsigned TOG_W       = (TOGGLES == 0) ? 1 : $clog2(TOGGLES + 1);
    localparam int unsigned SETTLE_W    = $clog2(SETTLE_CYCLES + 1);

    state_t                state_q, state_d;
    logic                  button_d, busy_d, settled_d;
    logic                  target_q, target_d;
    logic [HOLD_W-1:0]     hold_q, hold_d, hold_load;
    logic [TOG_W-1:0]      toggles_q, toggles_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic                  lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // Random level length in 1..GLITCH_MAX_CYCLES from the low LFSR bits.
    assign hold_load   = HOLD_W'(lfsr_q[GLITCH_BITS-1:0]) + HOLD_W'(1);
    assign lfsr_unused = ^lfsr_q[LFSR_WIDTH-1:GLITCH_BITS];

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            button    <= 1'b0;
            busy      <= 1'b0;
            settled   <= 1'b0;
            target_q  <= 1'b0;
            hold_q    <= '0;
            toggles_q <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            button    <= button_d;
            busy      <= busy_d;
            settled   <= settled_d;
            target_q  <= target_d;
            hold_q    <= hold_d;
            toggles_q <= toggles_d;
            settle_q  <= settle_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        button_d  = button;
        busy_d    = busy;
        settled_d = 1'b0;
        target_d  = target_q;
        hold_d    = hold_q;
        toggles_d = toggles_q;
        settle_d  = settle_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // The settled cycle itself is not a start opportunity, which
                // guarantees one fully idle cycle between sequences.
                if (!settled && (press != button)) begin
                    target_d  = press;
                    button_d  = press;
                    toggles_d = TOG_W'(TOGGLES);
                    hold_d    = hold_load;
                    busy_d    = 1'b1;
                    if (TOGGLES == 0) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_W'(SETTLE_CYCLES);
                    end else begin
                        state_d = BOUNCE;
                    end
                end
            end

            BOUNCE: begin
                if (hold_q > HOLD_W'(1)) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    button_d  = ~button;
                    toggles_d = toggles_q - TOG_W'(1);
                    hold_d    = hold_load;
                    // Toggle count is even, so the last toggle lands on target.
                    if (toggles_q == TOG_W'(1)) begin
                        state_d  = SETTLE;
                        settle_d = SETTLE_W'(SETTLE_CYCLES);
                    end
                end
            end

            SETTLE: begin
                button_d = target_q;
                if (settle_q <= SETTLE_W'(1)) begin
                    settle_d  = '0;
                    settled_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
